i2c_slave_responder: RTL and testbench

// - I2C target (slave) that answers the i2c_top_module master on the same scl/sda bus.
// - Built-in register file of 2**MEM_AW bytes with an auto-incrementing byte pointer, EEPROM-style:
//   - write: first data byte = pointer, later bytes = data.
//   - read: returns the byte at the pointer.
// - Drives sda open-drain only; it never drives scl, so there is no clock stretching.
// - Used as the bus partner in master benches and as an on-chip test responder.

---
 rtl/i2c_slave_responder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// I2C target with an auto-incrementing 2**MEM_AW byte register file (EEPROM-style access).
// scl/sda are synchronized and glitch-filtered; sda is driven open-drain via o_sda_oe.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         MEM_AW     = 4,
  parameter int         FILT_LEN   = 3
) (
  input  logic              i_sysclk,
  input  logic              i_reset,
  input  logic              i_scl,
  input  logic              i_sda,
  output logic              o_sda_oe,
  output logic              o_busy,
  output logic              o_wr_pulse,
  output logic [MEM_AW-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_stop_pulse
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] FILT_MAX = CW'(FILT_LEN - 1);
  localparam logic [MEM_AW-1:0] PTR_ONE = MEM_AW'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AACK, S_WPTR, S_WDATA, S_RBYTE, S_RACK, S_WSTOP
  } state_t;

  // Byte-boundary phases, each resolved on the next filtered scl falling edge.
  typedef enum logic [2:0] {
    PH_NONE, PH_ACK_PEND, PH_ACK_DRV, PH_REL, PH_LOAD
  } phase_t;

  function automatic logic [CW:0] filt_step(input logic s, input logic f,
                                            input logic [CW-1:0] cnt);
    logic [CW:0] r;
    if (s == f) r = {f, {CW{1'b0}}};
    else if (cnt == FILT_MAX) r = {s, {CW{1'b0}}};
    else r = {f, cnt + CW'(1'b1)};
    return r;
  endfunction

  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic scl_f_q, sda_f_q, scl_p_q, sda_p_q;
  logic [CW-1:0] scl_cnt_q, sda_cnt_q;
  logic [CW:0] scl_filt_d, sda_filt_d;

  state_t state_q, state_d;
  phase_t ph_q, ph_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic rw_q, rw_d, oe_q, oe_d, busy_q, busy_d;
  logic wr_pulse_q, wr_pulse_d, stop_pulse_q, stop_pulse_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_ev, stop_ev, byte_done;
  logic [7:0] byte_in;

  always_comb begin
    scl_filt_d = filt_step(scl_s2_q, scl_f_q, scl_cnt_q);
    sda_filt_d = filt_step(sda_s2_q, sda_f_q, sda_cnt_q);
    scl_rise   = scl_f_q & ~scl_p_q;
    scl_fall   = ~scl_f_q & scl_p_q;
    sda_rise   = sda_f_q & ~sda_p_q;
    sda_fall   = ~sda_f_q & sda_p_q;
    start_ev   = sda_fall & scl_f_q & scl_p_q;
    stop_ev    = sda_rise & scl_f_q & scl_p_q;
    byte_done  = scl_rise & (bit_cnt_q == 3'd7);
    byte_in    = {shift_q, sda_f_q};
  end

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ptr_d        = ptr_q;
    rw_d         = rw_q;
    oe_d         = oe_q;
    busy_d       = busy_q;
    wr_pulse_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    stop_pulse_d = 1'b0;
    mem_d        = mem_q;
    if (stop_ev) begin
      state_d      = S_IDLE;
      ph_d         = PH_NONE;
      bit_cnt_d    = 3'd0;
      oe_d         = 1'b0;
      busy_d       = 1'b0;
      stop_pulse_d = 1'b1;
    end else if (start_ev) begin
      // Repeated START keeps the pointer so a pointer write can be followed by a read.
      state_d   = S_ADDR;
      ph_d      = PH_NONE;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
    end else if (ph_q != PH_NONE) begin
      if (scl_fall) begin
        case (ph_q)
          PH_ACK_PEND: begin
            oe_d = 1'b1;
            ph_d = PH_ACK_DRV;
          end
          PH_ACK_DRV: begin
            oe_d      = 1'b0;
            ph_d      = PH_NONE;
            bit_cnt_d = 3'd0;
            if (state_q == S_AACK) begin
              if (rw_q) begin
                state_d = S_RBYTE;
                shift_d = mem_q[ptr_q][6:0];
                oe_d    = ~mem_q[ptr_q][7];
              end else begin
                state_d = S_WPTR;
              end
            end else begin
              state_d = state_q;
            end
          end
          PH_REL: begin
            oe_d    = 1'b0;
            ph_d    = PH_NONE;
            state_d = S_RACK;
          end
          PH_LOAD: begin
            ph_d      = PH_NONE;
            bit_cnt_d = 3'd0;
            state_d   = S_RBYTE;
            shift_d   = mem_q[ptr_q][6:0];
            oe_d      = ~mem_q[ptr_q][7];
          end
          default: begin
            oe_d    = 1'b0;
            ph_d    = PH_NONE;
            state_d = S_IDLE;
          end
        endcase
      end else begin
        ph_d = ph_q;
      end
    end else begin
      case (state_q)
        S_ADDR, S_WPTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            shift_d = shift_q;
          end
          if (byte_done) begin
            if (state_q == S_ADDR) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state_d = S_AACK;
                rw_d    = byte_in[0];
                busy_d  = 1'b1;
                ph_d    = PH_ACK_PEND;
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
              end
            end else if (state_q == S_WPTR) begin
              ptr_d   = byte_in[MEM_AW-1:0];
              state_d = S_WDATA;
              ph_d    = PH_ACK_PEND;
            end else begin
              mem_d[ptr_q] = byte_in;
              wr_pulse_d   = 1'b1;
              wr_addr_d    = ptr_q;
              wr_data_d    = byte_in;
              ptr_d        = ptr_q + PTR_ONE;
              ph_d         = PH_ACK_PEND;
            end
          end else begin
            state_d = state_q;
          end
        end
        S_RBYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            ph_d      = (bit_cnt_q == 3'd7) ? PH_REL : PH_NONE;
          end else if (scl_fall) begin
            shift_d = {shift_q[5:0], 1'b0};
            oe_d    = ~shift_q[6];
          end else begin
            shift_d = shift_q;
          end
        end
        S_RACK: begin
          if (scl_rise) begin
            ptr_d = ptr_q + PTR_ONE;
            if (!sda_f_q) ph_d = PH_LOAD;
            else state_d = S_WSTOP;
          end else begin
            ptr_d = ptr_q;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      scl_s1_q     <= 1'b1;
      scl_s2_q     <= 1'b1;
      sda_s1_q     <= 1'b1;
      sda_s2_q     <= 1'b1;
      scl_f_q      <= 1'b1;
      sda_f_q      <= 1'b1;
      scl_p_q      <= 1'b1;
      sda_p_q      <= 1'b1;
      scl_cnt_q    <= {CW{1'b0}};
      sda_cnt_q    <= {CW{1'b0}};
      state_q      <= S_IDLE;
      ph_q         <= PH_NONE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      ptr_q        <= {MEM_AW{1'b0}};
      rw_q         <= 1'b0;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
      wr_pulse_q   <= 1'b0;
      wr_addr_q    <= {MEM_AW{1'b0}};
      wr_data_q    <= 8'h00;
      stop_pulse_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      scl_s1_q     <= i_scl;
      scl_s2_q     <= scl_s1_q;
      sda_s1_q     <= i_sda;
      sda_s2_q     <= sda_s1_q;
      scl_f_q      <= scl_filt_d[CW];
      sda_f_q      <= sda_filt_d[CW];
      scl_cnt_q    <= scl_filt_d[CW-1:0];
      sda_cnt_q    <= sda_filt_d[CW-1:0];
      scl_p_q      <= scl_f_q;
      sda_p_q      <= sda_f_q;
      state_q      <= state_d;
      ph_q         <= ph_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      rw_q         <= rw_d;
      oe_q         <= oe_d;
      busy_q       <= busy_d;
      wr_pulse_q   <= wr_pulse_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      stop_pulse_q <= stop_pulse_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign o_sda_oe     = oe_q;
  assign o_busy       = busy_q;
  assign o_wr_pulse   = wr_pulse_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_stop_pulse = stop_pulse_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master, table of transfers, write/read scoreboards.
module tb_i2c_slave_responder;

  localparam int T = 12;

  logic clk = 1'b0;
  logic i_reset, scl_m, sda_m;
  logic i_scl, i_sda;
  logic o_sda_oe, o_busy, o_wr_pulse, o_stop_pulse;
  logic [3:0] o_wr_addr;
  logic [7:0] o_wr_data;

  assign i_scl = scl_m;
  assign i_sda = sda_m & ~o_sda_oe;

  always #5 clk = ~clk;

  i2c_slave_responder #(.SLAVE_ADDR(7'h50), .MEM_AW(4), .FILT_LEN(3)) dut (
    .i_sysclk(clk), .i_reset(i_reset), .i_scl(i_scl), .i_sda(i_sda),
    .o_sda_oe(o_sda_oe), .o_busy(o_busy), .o_wr_pulse(o_wr_pulse),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_stop_pulse(o_stop_pulse)
  );

  typedef enum logic [1:0] {K_WR, K_RD_RS, K_RD_CUR, K_BAD} kind_e;
  typedef struct {
    kind_e           kind;
    logic [7:0]      dev;
    logic [7:0]      ptr;
    int              n;
    logic [3:0][7:0] d;    // write data or expected read data
    logic            ack;  // expected address ACK
  } vec_t;

  vec_t vecs[8];
  logic [11:0] wr_q[$];
  logic [7:0]  rd_q[$];
  int n_vec = 0, n_err = 0, stop_cnt = 0, exp_stop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every wait advances through here so output strobes are never missed.
  task automatic tick();
    logic [11:0] e;
    @(negedge clk);
    if (o_stop_pulse === 1'b1) stop_cnt++;
    if (o_wr_pulse === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", o_wr_addr, o_wr_data);
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", {28'd0, o_wr_addr}, {28'd0, e[11:8]});
        check("wr_data", {24'd0, o_wr_data}, {24'd0, e[7:0]});
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic write_bit(input logic b, input int g);
    wait_cyc(T);
    sda_m = b;
    if (g > 0) begin
      wait_cyc(4); scl_m = 1'b1; wait_cyc(g); scl_m = 1'b0; wait_cyc(T - 4 - g);
    end else begin
      wait_cyc(T);
    end
    scl_m = 1'b1;
    if (g > 0) begin
      wait_cyc(T - 2); sda_m = ~b; wait_cyc(g); sda_m = b; wait_cyc(T + 2 - g);
    end else begin
      wait_cyc(2 * T);
    end
    scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_cyc(4);
    sda_m = 1'b1;
    wait_cyc(2 * T - 4);
    scl_m = 1'b1;
    wait_cyc(T);
    b = i_sda;
    wait_cyc(T);
    scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit glitch, output logic nack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], glitch ? ((i % 2) + 1) : 0);
    read_bit(nack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack, 0);
  endtask

  task automatic start_c();
    sda_m = 1'b0; wait_cyc(2 * T); scl_m = 1'b0;
  endtask

  task automatic restart_c();
    wait_cyc(T); sda_m = 1'b1; wait_cyc(T); scl_m = 1'b1;
    wait_cyc(2 * T); sda_m = 1'b0; wait_cyc(2 * T); scl_m = 1'b0;
  endtask

  task automatic stop_c();
    wait_cyc(T); sda_m = 1'b0; wait_cyc(T); scl_m = 1'b1;
    wait_cyc(2 * T); sda_m = 1'b1; wait_cyc(2 * T);
    exp_stop++;
    wait_cyc(T);
    check("stop_pulse_count", stop_cnt, exp_stop);
    check("busy_after_stop", {31'd0, o_busy}, 32'd0);
    check("oe_after_stop", {31'd0, o_sda_oe}, 32'd0);
  endtask

  task automatic do_reads(input vec_t v);
    logic [7:0] got, exp;
    for (int i = 0; i < v.n; i++) begin
      rd_q.push_back(v.d[i]);
      recv_byte(i == v.n - 1, got);
      exp = rd_q.pop_front();
      check("read_data", {24'd0, got}, {24'd0, exp});
    end
    wait_cyc(8);
    check("oe_released_after_nack", {31'd0, o_sda_oe}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic nack;
    start_c();
    send_byte(v.dev, 1'b0, nack);
    check("addr_ack", {31'd0, nack}, {31'd0, ~v.ack});
    check("busy_after_addr", {31'd0, o_busy}, {31'd0, v.ack});
    if (v.kind == K_WR || v.kind == K_RD_RS) begin
      send_byte(v.ptr, 1'b0, nack);
      check("ptr_ack", {31'd0, nack}, 32'd0);
    end
    if (v.kind == K_WR) begin
      for (int i = 0; i < v.n; i++) begin
        wr_q.push_back({v.ptr[3:0] + 4'(i), v.d[i]});
        send_byte(v.d[i], 1'b0, nack);
        check("data_ack", {31'd0, nack}, 32'd0);
      end
      check("wr_pending", wr_q.size(), 0);
    end else if (v.kind == K_RD_RS) begin
      restart_c();
      send_byte(v.dev | 8'h01, 1'b0, nack);
      check("raddr_ack", {31'd0, nack}, 32'd0);
      check("busy_after_restart", {31'd0, o_busy}, 32'd1);
      do_reads(v);
    end else if (v.kind == K_RD_CUR) begin
      do_reads(v);
    end
    stop_c();
  endtask

  initial begin
    logic nack;
    vecs[0] = '{K_WR,     8'hA0, 8'h02, 2, {8'h00, 8'h00, 8'h52, 8'h51}, 1'b1};
    vecs[1] = '{K_RD_CUR, 8'hA1, 8'h00, 1, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b1};
    vecs[2] = '{K_RD_RS,  8'hA0, 8'h02, 2, {8'h00, 8'h00, 8'h52, 8'h51}, 1'b1};
    vecs[3] = '{K_BAD,    8'hA2, 8'h00, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0};
    vecs[4] = '{K_WR,     8'hA0, 8'h0F, 3, {8'h00, 8'hCC, 8'hBB, 8'hAA}, 1'b1};
    vecs[5] = '{K_RD_RS,  8'hA0, 8'h0F, 3, {8'h00, 8'hCC, 8'hBB, 8'hAA}, 1'b1};
    vecs[6] = '{K_RD_RS,  8'hA0, 8'h08, 1, {8'h00, 8'h00, 8'h00, 8'h3C}, 1'b1};
    vecs[7] = '{K_RD_CUR, 8'hA1, 8'h00, 1, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b1};

    i_reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    wait_cyc(5);
    check("rst_oe", {31'd0, o_sda_oe}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_wr_pulse", {31'd0, o_wr_pulse}, 32'd0);
    check("rst_stop_pulse", {31'd0, o_stop_pulse}, 32'd0);
    check("rst_wr_addr_data", {20'd0, o_wr_addr, o_wr_data}, 32'd0);
    i_reset = 1'b0;
    wait_cyc(10);

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Glitched data byte: no extra bit, no false START/STOP, byte lands intact.
    start_c();
    send_byte(8'hA0, 1'b0, nack);
    check("g_addr_ack", {31'd0, nack}, 32'd0);
    send_byte(8'h08, 1'b1, nack);
    check("g_ptr_ack", {31'd0, nack}, 32'd0);
    wr_q.push_back({4'h8, 8'h3C});
    send_byte(8'h3C, 1'b1, nack);
    check("g_data_ack", {31'd0, nack}, 32'd0);
    check("g_busy", {31'd0, o_busy}, 32'd1);
    stop_c();
    run_vec(vecs[6]);

    // Reset while the responder drives a 0 read bit.
    start_c();
    send_byte(8'hA0, 1'b0, nack);
    send_byte(8'h07, 1'b0, nack);
    restart_c();
    send_byte(8'hA1, 1'b0, nack);
    check("rr_addr_ack", {31'd0, nack}, 32'd0);
    wait_cyc(T);
    check("rr_oe_driving", {31'd0, o_sda_oe}, 32'd1);
    i_reset = 1'b1;
    tick();
    check("rr_oe_released", {31'd0, o_sda_oe}, 32'd0);
    check("rr_busy_cleared", {31'd0, o_busy}, 32'd0);
    i_reset = 1'b0;
    scl_m = 1'b1; sda_m = 1'b1;
    wait_cyc(4 * T);
    check("rr_no_stop", stop_cnt, exp_stop);
    run_vec(vecs[7]);

    check("wr_queue_empty", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
